// File: rtl/rv_issue_arbiter.sv
// rv_issue_arbiter: round-robin issue scheduler for the shared rv32i instruction bus.
//
// Purpose:
//   NUM_REQ instruction sources compete for one 32-bit bus. One instruction is issued at a
//   time with a valid/ack handshake. A credit counter limits how many acked instructions
//   may be awaiting retirement at once.
//
// Ports:
//   clock        in   1                     single clock, posedge
//   reset_n      in   1                     synchronous active-low reset
//   req_valid    in   NUM_REQ               requester i has an instruction
//   req_instr    in   NUM_REQ*32            instruction of requester i at [32*i +: 32]
//   req_ready    out  NUM_REQ               one-cycle pulse: requester i's instruction taken
//   rv32i        out  32                    instruction on the bus
//   rv_valid     out  1                     rv32i valid, held until rv_ack
//   rv_ack       in   1                     consumer accepted rv32i this cycle
//   op_retire    in   1                     one outstanding instruction retired
//   grant_id     out  clog2(NUM_REQ)        source of the current/last rv32i
//   outstanding  out  clog2(MAX_OUTSTANDING+1)  acked-not-retired count
//   retire_err   out  1                     sticky: retire seen with nothing outstanding
//
// Configuration:
//   RV_ISSUE_NOP_FILL_EN - when defined, an idle bus with credit available issues NOP
//   (0x00000013) as a normal handshaked instruction tagged grant_id = NUM_REQ-1.

module rv_issue_arbiter #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*32-1:0]                req_instr,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [31:0]                          rv32i,
    output logic                                 rv_valid,
    input  logic                                 rv_ack,
    input  logic                                 op_retire,
    output logic [$clog2(NUM_REQ)-1:0]           grant_id,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 retire_err
);

    localparam int unsigned GW  = $clog2(NUM_REQ);
    localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [GW-1:0]     rr_ptr;
    logic [GW-1:0]     pick;
    logic [GW-1:0]     ptr_next;
    logic              found;
    logic              any_req;
    logic              ack_fire;
    logic              retire_ok;
    logic              credit_ok;
    logic              load;
    logic              load_nop;
    logic [31:0]       sel_instr;
    logic [NUM_REQ-1:0] ready_d;
    logic [OW-1:0]     outstanding_d;

    assign any_req   = |req_valid;
    assign ack_fire  = rv_ack & rv_valid;
    assign retire_ok = op_retire & (outstanding != '0);
    // Credit check counts an ack landing in the same cycle as the new load.
    assign credit_ok = (32'(outstanding) + 32'(ack_fire)) < MAX_OUTSTANDING;

    // Round-robin pick: first active requester at or above rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[GW'((32'(rr_ptr) + k) % NUM_REQ)]) begin
                found = 1'b1;
                pick  = GW'((32'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign ptr_next = GW'((32'(pick) + 32'd1) % NUM_REQ);

    // Instruction mux and one-hot ready for the picked source.
    always_comb begin
        sel_instr = '0;
        ready_d   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == pick) begin
                sel_instr  = req_instr[32*i +: 32];
                ready_d[i] = load;
            end
        end
    end

    // Outstanding count: ack and retire together cancel.
    always_comb begin
        outstanding_d = outstanding;
        if (ack_fire && !retire_ok) begin
            outstanding_d = outstanding + OW'(1);
        end else if (!ack_fire && retire_ok) begin
            outstanding_d = outstanding - OW'(1);
        end
    end

    // Next-state and load decisions.
    always_comb begin
        state_d  = state;
        load     = 1'b0;
        load_nop = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    if (credit_ok) begin
                        load    = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = STALL;
                    end
                end
`ifdef RV_ISSUE_NOP_FILL_EN
                else if (credit_ok) begin
                    load_nop = 1'b1;
                    state_d  = ISSUE;
                end
`endif
            end
            ISSUE: begin
                if (rv_ack) begin
                    if (any_req && credit_ok) begin
                        load = 1'b1;
                    end else if (any_req) begin
                        state_d = STALL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            STALL: begin
                if (!any_req) begin
                    state_d = IDLE;
                end else if (credit_ok) begin
                    load    = 1'b1;
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Bus, grant, credit and error registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rv32i       <= '0;
            rv_valid    <= 1'b0;
            req_ready   <= '0;
            grant_id    <= '0;
            rr_ptr      <= '0;
            outstanding <= '0;
            retire_err  <= 1'b0;
        end else begin
            rv_valid    <= (state_d == ISSUE);
            req_ready   <= ready_d;
            outstanding <= outstanding_d;
            if (op_retire && (outstanding == '0)) begin
                retire_err <= 1'b1;
            end
            if (load) begin
                rv32i    <= sel_instr;
                grant_id <= pick;
                rr_ptr   <= ptr_next;
            end else if (load_nop) begin
                rv32i    <= NOP;
                grant_id <= GW'(NUM_REQ - 1);
            end
        end
    end

endmodule

// File: tb/tb_rv_issue_arbiter.sv
// Self-checking bench for rv_issue_arbiter (NUM_REQ=4, MAX_OUTSTANDING=4).
module tb_rv_issue_arbiter;

    localparam int N    = 4;
    localparam int MAXO = 4;

    logic         clock;
    logic         reset_n;
    logic [3:0]   req_valid;
    logic [127:0] req_instr;
    logic [3:0]   req_ready;
    logic [31:0]  rv32i;
    logic         rv_valid;
    logic         rv_ack;
    logic         op_retire;
    logic [1:0]   grant_id;
    logic [2:0]   outstanding;
    logic         retire_err;

    int vectors;
    int miscompares;

    // Reference model state
    logic [31:0] m_instr;
    logic        m_valid;
    logic [1:0]  m_gid;
    logic [3:0]  m_ready;
    int          m_out;
    logic        m_err;
    int          m_ptr;
    logic        m_idle;

    rv_issue_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(MAXO)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_instr   (req_instr),
        .req_ready   (req_ready),
        .rv32i       (rv32i),
        .rv_valid    (rv_valid),
        .rv_ack      (rv_ack),
        .op_retire   (op_retire),
        .grant_id    (grant_id),
        .outstanding (outstanding),
        .retire_err  (retire_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Transaction-level model: bus slot is either occupied or free; a free slot is refilled
    // from the next requester in rotation whenever the credit budget allows.
    task automatic model_update();
        logic        ack;
        int          budget;
        int          sel;
        logic [3:0]  rv;
        if (!reset_n) begin
            m_instr = '0; m_valid = 0; m_gid = '0; m_ready = '0;
            m_out = 0; m_err = 0; m_ptr = 0; m_idle = 1;
            return;
        end
        rv      = req_valid;
        ack     = rv_ack && m_valid;
        budget  = m_out + (ack ? 1 : 0);
        m_ready = '0;
        if (op_retire && m_out == 0) m_err = 1;
        m_out = m_out + (ack ? 1 : 0) - ((op_retire && m_out > 0) ? 1 : 0);
        if (!m_valid || ack) begin
            sel = -1;
            for (int k = 0; k < N; k++)
                if (sel < 0 && rv[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
            if (sel >= 0 && budget < MAXO) begin
                m_instr = req_instr[32*sel +: 32];
                m_gid = 2'(sel);
                m_ready[sel] = 1'b1;
                m_ptr = (sel + 1) % N;
                m_valid = 1; m_idle = 0;
            end else if (sel >= 0) begin
                m_valid = 0; m_idle = 0;
            end
`ifdef RV_ISSUE_NOP_FILL_EN
            else if (!m_valid && m_idle && budget < MAXO) begin
                m_instr = 32'h0000_0013; m_gid = 2'(N - 1);
                m_valid = 1; m_idle = 0;
            end
`endif
            else begin
                m_valid = 0; m_idle = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 0; req_valid = '0; rv_ack = 0; op_retire = 0;
        tick(); tick();
        reset_n = 1;
    endtask

    task automatic test_reset();
        reset_n = 0; req_valid = 4'hF; rv_ack = 1; op_retire = 0;
        req_instr = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) tick();
        vectors++; if (rv_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rv_valid: got %b expected 0", rv_valid); end
        vectors++; if (outstanding !== 3'd0) begin miscompares++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
        vectors++; if (req_ready !== 4'h0) begin miscompares++; $display("FAIL reset_req_ready: got %h expected 0", req_ready); end
        vectors++; if (grant_id !== 2'd0) begin miscompares++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
        vectors++; if (rv32i !== 32'h0) begin miscompares++; $display("FAIL reset_rv32i: got %h expected 0", rv32i); end
        vectors++; if (retire_err !== 1'b0) begin miscompares++; $display("FAIL reset_retire_err: got %b expected 0", retire_err); end
        reset_n = 1; req_valid = '0; rv_ack = 0;
    endtask

    task automatic test_round_robin();
        logic [31:0] src [4];
        do_reset();
        for (int i = 0; i < N; i++) begin
            src[i] = $urandom;
            req_instr[32*i +: 32] = src[i];
        end
        req_valid = 4'hF; rv_ack = 1; op_retire = 0;
        for (int t = 0; t < 6; t++) begin
            if (t >= 2) op_retire = 1;
            tick();
            vectors++; if (grant_id !== 2'(t % N)) begin miscompares++; $display("FAIL rr_grant_id[%0d]: got %0d expected %0d", t, grant_id, t % N); end
            vectors++; if (rv32i !== src[t % N]) begin miscompares++; $display("FAIL rr_rv32i[%0d]: got %h expected %h", t, rv32i, src[t % N]); end
            vectors++; if (rv_valid !== 1'b1) begin miscompares++; $display("FAIL rr_rv_valid[%0d]: got %b expected 1", t, rv_valid); end
            vectors++; if (req_ready !== 4'(1 << (t % N))) begin miscompares++; $display("FAIL rr_req_ready[%0d]: got %h expected %h", t, req_ready, 4'(1 << (t % N))); end
            vectors++; if (outstanding !== ((t == 0) ? 3'd0 : 3'd1)) begin miscompares++; $display("FAIL rr_outstanding[%0d]: got %0d expected %0d", t, outstanding, (t == 0) ? 0 : 1); end
        end
        req_valid = '0; rv_ack = 0; op_retire = 0;
    endtask

    task automatic test_credit_stall();
        int pulses;
        do_reset();
        req_instr = {$urandom, $urandom, $urandom, $urandom};
        req_valid = 4'b0010; rv_ack = 1; op_retire = 0;
        pulses = 0;
        repeat (10) begin
            tick();
            if (req_ready[1]) pulses++;
            vectors++; if (rv_valid !== m_valid) begin miscompares++; $display("FAIL credit_rv_valid: got %b expected %b", rv_valid, m_valid); end
        end
        vectors++; if (pulses !== 4) begin miscompares++; $display("FAIL credit_issue_count: got %0d expected 4", pulses); end
        vectors++; if (rv_valid !== 1'b0) begin miscompares++; $display("FAIL credit_stall_valid: got %b expected 0", rv_valid); end
        vectors++; if (outstanding !== 3'd4) begin miscompares++; $display("FAIL credit_full: got %0d expected 4", outstanding); end
        op_retire = 1;
        tick();
        op_retire = 0;
        pulses = 0;
        repeat (6) begin
            tick();
            if (req_ready[1]) pulses++;
        end
        vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL credit_after_retire: got %0d expected 1", pulses); end
        vectors++; if (outstanding !== 3'd4) begin miscompares++; $display("FAIL credit_refull: got %0d expected 4", outstanding); end
        vectors++; if (rv_valid !== 1'b0) begin miscompares++; $display("FAIL credit_restall: got %b expected 0", rv_valid); end
        req_valid = '0; rv_ack = 0;
    endtask

    task automatic test_hold();
        int pulses;
        do_reset();
        req_instr = {$urandom, $urandom, $urandom, 32'h00A0_0093};
        req_valid = 4'b0001; rv_ack = 0;
        tick();
        pulses = req_ready[0] ? 1 : 0;
        vectors++; if (rv32i !== 32'h00A0_0093) begin miscompares++; $display("FAIL hold_load: got %h expected 00a00093", rv32i); end
        for (int c = 0; c < 5; c++) begin
            tick();
            if (req_ready[0]) pulses++;
            vectors++; if (rv_valid !== 1'b1) begin miscompares++; $display("FAIL hold_valid[%0d]: got %b expected 1", c, rv_valid); end
            vectors++; if (rv32i !== 32'h00A0_0093) begin miscompares++; $display("FAIL hold_rv32i[%0d]: got %h expected 00a00093", c, rv32i); end
            vectors++; if (grant_id !== 2'd0) begin miscompares++; $display("FAIL hold_grant[%0d]: got %0d expected 0", c, grant_id); end
        end
        vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL hold_ready_pulses: got %0d expected 1", pulses); end
        req_valid = '0; rv_ack = 1;
        tick();
        vectors++; if (rv_valid !== 1'b0) begin miscompares++; $display("FAIL hold_release: got %b expected 0", rv_valid); end
        vectors++; if (outstanding !== 3'd1) begin miscompares++; $display("FAIL hold_outstanding: got %0d expected 1", outstanding); end
        rv_ack = 0;
    endtask

    task automatic test_simul_err();
        do_reset();
        req_instr = {$urandom, $urandom, $urandom, $urandom};
        req_valid = 4'b0001; rv_ack = 1; op_retire = 0;
        repeat (3) tick();
        vectors++; if (outstanding !== 3'd2) begin miscompares++; $display("FAIL simul_pre: got %0d expected 2", outstanding); end
        op_retire = 1;
        tick();
        vectors++; if (outstanding !== 3'd2) begin miscompares++; $display("FAIL simul_ack_retire: got %0d expected 2", outstanding); end
        op_retire = 0; req_valid = '0;
        tick();
        vectors++; if (outstanding !== 3'd3) begin miscompares++; $display("FAIL simul_drain: got %0d expected 3", outstanding); end
        rv_ack = 0; op_retire = 1;
        repeat (4) tick();
        vectors++; if (outstanding !== 3'd0) begin miscompares++; $display("FAIL err_outstanding: got %0d expected 0", outstanding); end
        vectors++; if (retire_err !== 1'b1) begin miscompares++; $display("FAIL err_set: got %b expected 1", retire_err); end
        op_retire = 0;
        repeat (3) tick();
        vectors++; if (retire_err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b expected 1", retire_err); end
        reset_n = 0;
        tick();
        vectors++; if (retire_err !== 1'b0) begin miscompares++; $display("FAIL err_clear: got %b expected 0", retire_err); end
        reset_n = 1;
    endtask

    task automatic test_midop_reset();
        do_reset();
        req_instr = {$urandom, $urandom, $urandom, $urandom | 32'h1};
        req_valid = 4'b0001; rv_ack = 0;
        tick();
        vectors++; if (rv_valid !== 1'b1) begin miscompares++; $display("FAIL midop_issue: got %b expected 1", rv_valid); end
        reset_n = 0;
        tick();
        vectors++; if (rv_valid !== 1'b0) begin miscompares++; $display("FAIL midop_drop: got %b expected 0", rv_valid); end
        vectors++; if (rv32i !== 32'h0) begin miscompares++; $display("FAIL midop_rv32i: got %h expected 0", rv32i); end
        reset_n = 1; req_valid = '0;
        tick();
`ifdef RV_ISSUE_NOP_FILL_EN
        vectors++; if (rv_valid !== 1'b1) begin miscompares++; $display("FAIL nop_valid: got %b expected 1", rv_valid); end
        vectors++; if (rv32i !== 32'h0000_0013) begin miscompares++; $display("FAIL nop_rv32i: got %h expected 00000013", rv32i); end
        vectors++; if (grant_id !== 2'd3) begin miscompares++; $display("FAIL nop_grant: got %0d expected 3", grant_id); end
        vectors++; if (req_ready !== 4'h0) begin miscompares++; $display("FAIL nop_ready: got %h expected 0", req_ready); end
`else
        vectors++; if (rv_valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid: got %b expected 0", rv_valid); end
        vectors++; if (rv32i !== 32'h0) begin miscompares++; $display("FAIL idle_rv32i: got %h expected 0", rv32i); end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            reset_n   = ($urandom_range(0, 79) != 0);
            req_valid = 4'($urandom & $urandom);
            req_instr = {$urandom, $urandom, $urandom, $urandom};
            rv_ack    = 1'($urandom_range(0, 1));
            op_retire = ($urandom_range(0, 2) == 0);
            tick();
            vectors++; if (rv_valid !== m_valid) begin miscompares++; $display("FAIL rnd_valid[%0d]: got %b expected %b", c, rv_valid, m_valid); end
            vectors++; if (rv32i !== m_instr) begin miscompares++; $display("FAIL rnd_rv32i[%0d]: got %h expected %h", c, rv32i, m_instr); end
            vectors++; if (grant_id !== m_gid) begin miscompares++; $display("FAIL rnd_grant[%0d]: got %0d expected %0d", c, grant_id, m_gid); end
            vectors++; if (req_ready !== m_ready) begin miscompares++; $display("FAIL rnd_ready[%0d]: got %h expected %h", c, req_ready, m_ready); end
            vectors++; if (outstanding !== 3'(m_out)) begin miscompares++; $display("FAIL rnd_outstanding[%0d]: got %0d expected %0d", c, outstanding, m_out); end
            vectors++; if (retire_err !== m_err) begin miscompares++; $display("FAIL rnd_err[%0d]: got %b expected %b", c, retire_err, m_err); end
        end
        reset_n = 1; req_valid = '0; rv_ack = 0; op_retire = 0;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset_n = 0; req_valid = '0; req_instr = '0; rv_ack = 0; op_retire = 0;
        m_instr = '0; m_valid = 0; m_gid = '0; m_ready = '0;
        m_out = 0; m_err = 0; m_ptr = 0; m_idle = 1;
        test_reset();
        test_round_robin();
        test_credit_stall();
        test_hold();
        test_simul_err();
        test_midop_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
